// File: rtl/present_key_sched_pkg.sv
//------------------------------------------------------------------------------
// present_pkg : PRESENT S-boxes, key-schedule FSM encoding and widths
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package present_pkg;

   localparam int RK_W  = 64;
   localparam int IDX_W = 5;

   // nibble n of each table holds S(n) / S^-1(n)
   localparam logic [63:0] PRESENT_SBOX     = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] PRESENT_INV_SBOX = 64'hA970_364B_D21C_8FE5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WIND   = 3'd1,
      EMIT_F = 3'd2,
      EMIT_B = 3'd3,
      DONE   = 3'd4
   } ks_state_e;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      return PRESENT_SBOX[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
      return PRESENT_INV_SBOX[{x, 2'b00} +: 4];
   endfunction

endpackage

`default_nettype wire

// File: rtl/present_key_sched_if.sv
//------------------------------------------------------------------------------
// present_key_sched_if : control and round-key stream of the key scheduler
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface present_key_sched_if #(
   parameter int KEY_SIZE = 80
);
   import present_pkg::*;

   logic                start;
   logic                decrypt;
   logic [KEY_SIZE-1:0] key;
   logic [RK_W-1:0]     rk;
   logic [IDX_W-1:0]    rk_idx;
   logic                rk_valid;
   logic                rk_ready;
   logic                busy;
   logic                done;

   modport master (
      input  start, decrypt, key, rk_ready,
      output rk, rk_idx, rk_valid, busy, done
   );

   modport slave (
      output start, decrypt, key, rk_ready,
      input  rk, rk_idx, rk_valid, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/present_key_sched_ks_step.sv
//------------------------------------------------------------------------------
// present_ks_step : one forward (inv=0) or inverse (inv=1) PRESENT key update
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module present_ks_step
   import present_pkg::*;
#(
   parameter int KEY_SIZE = 80
) (
   input  wire logic [KEY_SIZE-1:0] state,
   input  wire logic [IDX_W-1:0]    idx,
   input  wire logic                inv,
   output logic      [KEY_SIZE-1:0] nxt
);

   localparam int XLO = (KEY_SIZE == 128) ? 62 : 15;

   logic [KEY_SIZE-1:0] w_fwd;
   logic [KEY_SIZE-1:0] w_bwd;
   logic [KEY_SIZE-1:0] w_unx;

   always_comb begin
      w_fwd = {state[KEY_SIZE-62:0], state[KEY_SIZE-1:KEY_SIZE-61]};
      w_fwd[KEY_SIZE-1 -: 4] = sbox4(w_fwd[KEY_SIZE-1 -: 4]);
      if (KEY_SIZE == 128) begin
         w_fwd[KEY_SIZE-5 -: 4] = sbox4(w_fwd[KEY_SIZE-5 -: 4]);
      end
      w_fwd[XLO +: IDX_W] = w_fwd[XLO +: IDX_W] ^ idx;
   end

   // inverse undoes the forward operations in reverse order
   always_comb begin
      w_unx = state;
      w_unx[XLO +: IDX_W] = w_unx[XLO +: IDX_W] ^ idx;
      w_unx[KEY_SIZE-1 -: 4] = inv_sbox4(w_unx[KEY_SIZE-1 -: 4]);
      if (KEY_SIZE == 128) begin
         w_unx[KEY_SIZE-5 -: 4] = inv_sbox4(w_unx[KEY_SIZE-5 -: 4]);
      end
      w_bwd = {w_unx[60:0], w_unx[KEY_SIZE-1:61]};
   end

   assign nxt = inv ? w_bwd : w_fwd;

endmodule

`default_nettype wire

// File: rtl/present_key_sched.sv
//------------------------------------------------------------------------------
// present_key_sched : sequential PRESENT round-key generator (80/128-bit keys)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module present_key_sched
   import present_pkg::*;
#(
   parameter int KEY_SIZE   = 80,
   parameter int NUM_ROUNDS = 31
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   present_key_sched_if.master bus
);

   localparam logic [2:0]       C_ST_IDLE   = IDLE;
   localparam logic [2:0]       C_ST_WIND   = WIND;
   localparam logic [2:0]       C_ST_EMIT_F = EMIT_F;
   localparam logic [2:0]       C_ST_EMIT_B = EMIT_B;
   localparam logic [2:0]       C_ST_DONE   = DONE;
   localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_ROUNDS + 1);
   localparam logic [IDX_W-1:0] C_WIND_END  = IDX_W'(NUM_ROUNDS);

   generate
      if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
         $error("present_key_sched: KEY_SIZE must be 80 or 128");
      end
   endgenerate

   logic [2:0]          r_state;
   logic [KEY_SIZE-1:0] r_key;
   logic [IDX_W-1:0]    r_idx;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;

   logic                w_inv;
   logic [IDX_W-1:0]    w_step_idx;
   logic [KEY_SIZE-1:0] w_step;
   logic                w_hs;

   // backward emission regenerates K(i-1) from K(i) using counter i-1
   assign w_inv      = (r_state == C_ST_EMIT_B);
   assign w_step_idx = w_inv ? (r_idx - IDX_W'(1)) : r_idx;
   assign w_hs       = r_valid && bus.rk_ready;

   present_ks_step #(
      .KEY_SIZE (KEY_SIZE)
   ) u_step (
      .state (r_key),
      .idx   (w_step_idx),
      .inv   (w_inv),
      .nxt   (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_ST_IDLE;
         r_key   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            C_ST_IDLE: begin
               if (bus.start) begin
                  r_key   <= bus.key;
                  r_idx   <= IDX_W'(1);
                  r_busy  <= 1'b1;
                  r_valid <= !bus.decrypt;
                  r_state <= bus.decrypt ? C_ST_WIND : C_ST_EMIT_F;
               end
            end
            C_ST_WIND: begin
               r_key <= w_step;
               r_idx <= r_idx + IDX_W'(1);
               if (r_idx == C_WIND_END) begin
                  r_valid <= 1'b1;
                  r_state <= C_ST_EMIT_B;
               end
            end
            C_ST_EMIT_F, C_ST_EMIT_B: begin
               if (w_hs) begin
                  if (r_idx == (w_inv ? IDX_W'(1) : C_IDX_LAST)) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= C_ST_DONE;
                  end else begin
                     r_key <= w_step;
                     r_idx <= w_inv ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
                  end
               end
            end
            C_ST_DONE: begin
               r_state <= C_ST_IDLE;
            end
            default: begin
               r_state <= C_ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rk       = r_key[KEY_SIZE-1 -: RK_W];
   assign bus.rk_idx   = r_idx;
   assign bus.rk_valid = r_valid;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_present_key_sched.sv
//------------------------------------------------------------------------------
// tb_present_key_sched : scoreboard bench for both key sizes plus step unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_present_key_sched;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   int           sel = 80;
   logic         start_in = 1'b0;
   logic         dec_in = 1'b0;
   logic         ready_in = 1'b0;
   logic [127:0] key_in = '0;

   int           n_pass = 0;
   int           n_total = 0;

   logic [63:0]  sb_rk [$];
   logic [4:0]   sb_idx [$];
   logic [63:0]  got [1:32];

   always #5 clk = ~clk;

   present_key_sched_if #(.KEY_SIZE(80))  if80 ();
   present_key_sched_if #(.KEY_SIZE(128)) if128 ();

   assign if80.start     = start_in && (sel == 80);
   assign if80.decrypt   = dec_in;
   assign if80.key       = key_in[79:0];
   assign if80.rk_ready  = ready_in;
   assign if128.start    = start_in && (sel == 128);
   assign if128.decrypt  = dec_in;
   assign if128.key      = key_in;
   assign if128.rk_ready = ready_in;

   present_key_sched #(.KEY_SIZE(80),  .NUM_ROUNDS(31)) dut80  (.clk(clk), .rst_n(rst_n), .bus(if80.master));
   present_key_sched #(.KEY_SIZE(128), .NUM_ROUNDS(31)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128.master));

   logic [63:0] o_rk;
   logic [4:0]  o_idx;
   logic        o_valid, o_busy, o_done;
   assign o_rk    = (sel == 80) ? if80.rk       : if128.rk;
   assign o_idx   = (sel == 80) ? if80.rk_idx   : if128.rk_idx;
   assign o_valid = (sel == 80) ? if80.rk_valid : if128.rk_valid;
   assign o_busy  = (sel == 80) ? if80.busy     : if128.busy;
   assign o_done  = (sel == 80) ? if80.done     : if128.done;

   logic [127:0] u_x, u_f, u_b;
   logic [4:0]   u_i;
   present_ks_step #(.KEY_SIZE(128)) u_fwd (.state(u_x), .idx(u_i), .inv(1'b0), .nxt(u_f));
   present_ks_step #(.KEY_SIZE(128)) u_bwd (.state(u_f), .idx(u_i), .inv(1'b1), .nxt(u_b));

   function automatic logic [3:0] sb_m(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [127:0] f_step(input logic [127:0] s, input int ks, input logic [4:0] i);
      logic [127:0] r;
      r = '0;
      if (ks == 80) begin
         r[79:0]   = {s[18:0], s[79:19]};
         r[79:76]  = sb_m(r[79:76]);
         r[19:15]  = r[19:15] ^ i;
      end else begin
         r          = {s[66:0], s[127:67]};
         r[127:124] = sb_m(r[127:124]);
         r[123:120] = sb_m(r[123:120]);
         r[66:62]   = r[66:62] ^ i;
      end
      return r;
   endfunction

   function automatic logic [63:0] rk_of(input logic [127:0] s, input int ks);
      return (ks == 80) ? s[79:16] : s[127:64];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // one complete key stream; inj>0 pulses a spurious start at that cycle
   task automatic run(input int ks, input logic [127:0] k, input logic dec, input bit rnd, input int inj);
      logic [127:0] s;
      logic [63:0]  keys [1:32];
      logic [63:0]  hold_rk, e_rk;
      logic [4:0]   hold_idx, e_idx;
      int           cyc, first_v;
      bit           stalled, fin;
      sel = ks;
      s = k;
      for (int i = 1; i <= 32; i++) begin
         keys[i] = rk_of(s, ks);
         if (i < 32) s = f_step(s, ks, 5'(i));
      end
      for (int i = 1; i <= 32; i++) begin
         int j;
         j = dec ? (33 - i) : i;
         sb_rk.push_back(keys[j]);
         sb_idx.push_back(5'(j));
      end
      @(negedge clk);
      key_in = k; dec_in = dec; start_in = 1'b1; ready_in = 1'b0;
      @(negedge clk);
      start_in = 1'b0;
      cyc = 1; first_v = -1; stalled = 1'b0; fin = 1'b0;
      hold_rk = '0; hold_idx = '0;
      chk("busy_after_start", o_busy, 1'b1);
      while (!fin && cyc < 2000) begin
         if (stalled) begin
            chk("stall_rk", o_rk, hold_rk);
            chk("stall_idx", o_idx, hold_idx);
            chk("stall_valid", o_valid, 1'b1);
         end
         if (o_valid && first_v < 0) first_v = cyc;
         if (cyc == inj) begin
            start_in = 1'b1; key_in = ~k; dec_in = !dec;
         end else begin
            start_in = 1'b0;
         end
         ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled  = 1'b0;
         if (o_valid && ready_in) begin
            if (sb_rk.size() == 0) begin
               chk("extra_key", o_valid, 1'b0);
               fin = 1'b1;
            end else begin
               e_rk  = sb_rk.pop_front();
               e_idx = sb_idx.pop_front();
               chk("rk", o_rk, e_rk);
               chk("rk_idx", o_idx, e_idx);
               if (o_idx != 5'd0) got[o_idx] = o_rk;
               if (sb_rk.size() == 0) fin = 1'b1;
            end
         end else if (o_valid) begin
            stalled  = 1'b1;
            hold_rk  = o_rk;
            hold_idx = o_idx;
         end
         @(negedge clk);
         cyc++;
      end
      start_in = 1'b0;
      ready_in = 1'b0;
      chk("keys_remaining", sb_rk.size(), 0);
      sb_rk.delete();
      sb_idx.delete();
      chk("first_valid_cycle", first_v, dec ? 32 : 1);
      chk("done_pulse", o_done, 1'b1);
      chk("busy_end", o_busy, 1'b0);
      chk("valid_end", o_valid, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", o_done, 1'b0);
   endtask

   initial begin
      logic [127:0] k;
      int           n;

      // reset values on both instances
      #1;
      sel = 80;  #1;
      chk("rst80_rk", o_rk, 0);   chk("rst80_idx", o_idx, 0);  chk("rst80_valid", o_valid, 0);
      chk("rst80_busy", o_busy, 0); chk("rst80_done", o_done, 0);
      sel = 128; #1;
      chk("rst128_rk", o_rk, 0);  chk("rst128_idx", o_idx, 0); chk("rst128_valid", o_valid, 0);
      chk("rst128_busy", o_busy, 0); chk("rst128_done", o_done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // zero key, encrypt, 80-bit
      run(80, '0, 1'b0, 1'b0, -1);
      chk("t1_k1", got[1], 64'h0000000000000000);
      chk("t1_k2", got[2], 64'hC000000000000000);

      // encrypt and decrypt, both key sizes
      k = {$urandom, $urandom, $urandom, $urandom};
      run(80, k, 1'b1, 1'b0, -1);
      run(128, k, 1'b0, 1'b0, -1);
      k = {$urandom, $urandom, $urandom, $urandom};
      run(128, k, 1'b1, 1'b0, -1);

      // random back-pressure
      k = {$urandom, $urandom, $urandom, $urandom};
      run(80, k, 1'b0, 1'b1, -1);
      run(128, k, 1'b1, 1'b1, -1);

      // spurious start during EMIT_F and during WIND
      k = {$urandom, $urandom, $urandom, $urandom};
      run(80, k, 1'b0, 1'b0, 5);
      run(128, k, 1'b1, 1'b1, 10);

      // asynchronous reset in the middle of a stream
      sel = 80;
      k = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      key_in = k; dec_in = 1'b0; start_in = 1'b1; ready_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      n = 0;
      while (o_idx != 5'd10 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_idx10", o_idx, 10);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rk", o_rk, 0);     chk("t5_idx", o_idx, 0);   chk("t5_valid", o_valid, 0);
      chk("t5_busy", o_busy, 0); chk("t5_done", o_done, 0);
      ready_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run(80, k, 1'b0, 1'b0, -1);
      chk("t5_restart_k1", got[1], k[79:16]);

      // step unit round trip
      for (int it = 0; it < 10000; it++) begin
         u_x = {$urandom, $urandom, $urandom, $urandom};
         u_i = 5'($urandom_range(1, 31));
         #1;
         chk("t6_inverse", u_b, u_x);
         if (it < 200) chk("t6_fwd_model", u_f, f_step(u_x, 128, u_i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
